// File: rtl/anc2_pkg.sv
// Shared types and constants for the ANC-2 coupler/typewriter device model.
package anc2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRINT,
    ST_KEY_HOLD,
    ST_KEY_GAP
  } anc2_state_t;

  localparam int LEV_W     = 5;
  localparam int PRT_W     = 6;
  localparam int CNT_W     = 16;
  localparam int FN_KEYS_N = 13;

  // Function-key positions on fn_keys
  localparam int CIR_S = 0;
  localparam int A     = 1;
  localparam int B     = 2;
  localparam int C     = 3;
  localparam int E     = 4;
  localparam int F     = 5;
  localparam int I     = 6;
  localparam int M     = 7;
  localparam int P     = 8;
  localparam int Q     = 9;
  localparam int R     = 10;
  localparam int T     = 11;
  localparam int FB    = 12;

  function automatic logic [FN_KEYS_N-1:0] fn_onehot(input logic [3:0] idx);
    logic [FN_KEYS_N-1:0] v;
    v = '0;
    for (int i = 0; i < FN_KEYS_N; i++) begin
      if (idx == 4'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic fn_idx_valid(input logic [3:0] idx);
    return idx < 4'(FN_KEYS_N);
  endfunction

endpackage

// File: rtl/anc2_prt_fifo.sv
// First-word fall-through print FIFO with registered head outputs and a
// sticky overflow flag.
module anc2_prt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         ovf
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("anc2_prt_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr_reg, rptr_reg, wptr_next, rptr_next;
  logic         valid_reg, ovf_reg;
  logic [W-1:0] data_reg;
  logic         full, empty, do_push, do_pop, head_is_new;

  assign empty   = (wptr_reg == rptr_reg);
  assign full    = (wptr_reg[AW] != rptr_reg[AW]) &&
                   (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  assign do_push = push & (~full | do_pop);

  assign rptr_next = rptr_reg + (AW+1)'(do_pop);
  assign wptr_next = wptr_reg + (AW+1)'(do_push);
  // The entry being written becomes the head when it lands at the next read pointer
  assign head_is_new = do_push && (rptr_next == wptr_reg);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_reg[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      valid_reg <= (wptr_next != rptr_next);
      data_reg  <= head_is_new ? push_data : mem[rptr_next[AW-1:0]];
      ovf_reg   <= ovf_reg | (push & ~do_push);
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;
  assign ovf   = ovf_reg;

endmodule

// File: rtl/anc2_coupler.sv
// ANC-2 coupler and typewriter: queues printed codes for the host and plays
// host keystrokes back to the CPU as timed level codes or key closures.
module anc2_coupler
  import anc2_pkg::*;
#(
  parameter int PRT_DEPTH = 4,
  parameter int PRINT_MS  = 60,
  parameter int KEY_MS    = 50,
  parameter int GAP_MS    = 20
) (
  input  logic             CLOCK,
  input  logic             rst_n,
  input  logic             tick_ms,
  input  logic             pl1_an,
  input  logic             pl1_type,
  input  logic             pl1_exc,
  input  logic [LEV_W-1:0] pl1_lev_in,
  output logic [LEV_W-1:0] pl1_lev_out,
  output logic [FN_KEYS_N-1:0] fn_keys,
  output logic             prt_valid,
  output logic [PRT_W-1:0] prt_data,
  input  logic             prt_ready,
  output logic             prt_ovf,
  input  logic             key_valid,
  input  logic [5:0]       key_data,
  output logic             key_ready,
  output logic             busy
);

  if (PRINT_MS < 1 || KEY_MS < 1 || GAP_MS < 1) begin : g_bad_ms
    $error("anc2_coupler: PRINT_MS, KEY_MS and GAP_MS must each be >= 1");
  end

  localparam int SY_AN   = 7;
  localparam int SY_TYPE = 6;
  localparam int SY_EXC  = 5;

  logic [7:0]       sync1_reg, sync2_reg;
  logic             exc_d_reg;
  logic             an_s, type_s, exc_s, exc_rise, exc_rise_next;
  logic [LEV_W-1:0] lev_in_s;

  anc2_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [LEV_W-1:0] echo_reg, echo_next;
  logic [5:0]       key_reg, key_next;
  logic [LEV_W-1:0] lev_out_reg, lev_out_next;
  logic [FN_KEYS_N-1:0] fn_reg, fn_next;
  logic             busy_reg, busy_next, ready_reg, ready_next;
  logic             push_reg;
  logic [PRT_W-1:0] push_data_reg;
  logic             key_fire, expire;

  assign an_s     = sync2_reg[SY_AN];
  assign type_s   = sync2_reg[SY_TYPE];
  assign exc_s    = sync2_reg[SY_EXC];
  assign lev_in_s = sync2_reg[LEV_W-1:0];
  assign exc_rise = exc_s & ~exc_d_reg;
  // Value exc_rise will take after the coming edge, for the registered key_ready
  assign exc_rise_next = sync1_reg[SY_EXC] & ~sync2_reg[SY_EXC];

  assign key_fire = key_valid & ready_reg;
  assign expire   = tick_ms && (cnt_reg == CNT_W'(1));

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg     <= '0;
      sync2_reg     <= '0;
      exc_d_reg     <= 1'b0;
      push_reg      <= 1'b0;
      push_data_reg <= '0;
    end else begin
      sync1_reg     <= {pl1_an, pl1_type, pl1_exc, pl1_lev_in};
      sync2_reg     <= sync1_reg;
      exc_d_reg     <= exc_s;
      push_reg      <= exc_rise;
      push_data_reg <= {an_s, lev_in_s};
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    echo_next  = echo_reg;
    key_next   = key_reg;
    if (state_reg != ST_IDLE && tick_ms && cnt_reg != '0) cnt_next = cnt_reg - CNT_W'(1);

    case (state_reg)
      ST_IDLE, ST_KEY_GAP: begin
        if (exc_rise) begin
          state_next = ST_PRINT;
          cnt_next   = CNT_W'(PRINT_MS);
          echo_next  = lev_in_s;
        end else if (state_reg == ST_KEY_GAP) begin
          if (expire) state_next = ST_IDLE;
        end else if (key_fire && (!key_data[5] || fn_idx_valid(key_data[3:0]))) begin
          // Out-of-range function indices are acknowledged but never played
          state_next = ST_KEY_HOLD;
          cnt_next   = CNT_W'(KEY_MS);
          key_next   = key_data;
        end
      end
      ST_PRINT: begin
        if (exc_rise) begin
          cnt_next  = CNT_W'(PRINT_MS);
          echo_next = lev_in_s;
        end else if (expire) begin
          state_next = ST_IDLE;
        end
      end
      ST_KEY_HOLD: begin
        if (expire) begin
          state_next = ST_KEY_GAP;
          cnt_next   = CNT_W'(GAP_MS);
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so the registers track the state
    lev_out_next = '0;
    fn_next      = '0;
    if (state_next == ST_PRINT) begin
      lev_out_next = echo_next;
    end else if (state_next == ST_KEY_HOLD) begin
      if (key_next[5]) fn_next = fn_onehot(key_next[3:0]);
      else             lev_out_next = key_next[LEV_W-1:0];
    end
    busy_next  = (state_next != ST_IDLE);
    ready_next = (state_next == ST_IDLE) & ~sync1_reg[SY_TYPE] & ~exc_rise_next;
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      echo_reg    <= '0;
      key_reg     <= '0;
      lev_out_reg <= '0;
      fn_reg      <= '0;
      busy_reg    <= 1'b0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      echo_reg    <= echo_next;
      key_reg     <= key_next;
      lev_out_reg <= lev_out_next;
      fn_reg      <= fn_next;
      busy_reg    <= busy_next;
      ready_reg   <= ready_next;
    end
  end

  anc2_prt_fifo #(
    .DEPTH(PRT_DEPTH),
    .W    (PRT_W)
  ) u_prt_fifo (
    .clk      (CLOCK),
    .rst_n    (rst_n),
    .push     (push_reg),
    .push_data(push_data_reg),
    .pop      (prt_valid & prt_ready),
    .valid    (prt_valid),
    .data     (prt_data),
    .ovf      (prt_ovf)
  );

  assign pl1_lev_out = lev_out_reg;
  assign fn_keys     = fn_reg;
  assign busy        = busy_reg;
  assign key_ready   = ready_reg;

endmodule
